// File: rtl/uart_tx_cfg_pkg.sv
// Shared definitions for the configurable UART transmitter.
//   tx_state_t   : transmitter FSM states
//   PAR_*        : par_mode encodings (11 behaves as PAR_NONE)
//   par_enabled  : true when a par_mode value requests a parity bit
package uart_tx_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    function automatic logic par_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_hold.sv
// One-entry holding register in front of the UART transmitter.
//   clk, reset          : clock, synchronous active-high reset
//   load                : a word is offered (tx_valid); accepted only while empty
//   load_data/par/stop2 : word and frame configuration offered with it
//   take                : the FSM consumes the entry (or the word being offered)
//   ready               : entry empty, an offered word is accepted this cycle
//   full                : entry holds a word
//   avail               : a word is available now, held or being accepted
//   data/par/stop2      : held word, or the offered one while empty (bypass)
module uart_tx_hold #(
    parameter int unsigned DBIT = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [DBIT-1:0] load_data,
    input  logic [1:0]      load_par,
    input  logic            load_stop2,
    input  logic            take,
    output logic            ready,
    output logic            full,
    output logic            avail,
    output logic [DBIT-1:0] data,
    output logic [1:0]      par,
    output logic            stop2
);

    logic            full_reg;
    logic [DBIT-1:0] data_reg;
    logic [1:0]      par_reg;
    logic            stop2_reg;
    logic            accept;

    assign accept = load && !full_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            full_reg <= 1'b0;
        end else if (accept && !take) begin
            full_reg  <= 1'b1;
            data_reg  <= load_data;
            par_reg   <= load_par;
            stop2_reg <= load_stop2;
        end else if (take) begin
            // Covers a take of the held word and a take of the word being
            // accepted this cycle; either way the entry ends up empty.
            full_reg <= 1'b0;
        end
    end

    assign ready = !full_reg;
    assign full  = full_reg;
    assign avail = full_reg || accept;
    assign data  = full_reg ? data_reg  : load_data;
    assign par   = full_reg ? par_reg   : load_par;
    assign stop2 = full_reg ? stop2_reg : load_stop2;

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-word parity and stop-length configuration.
//   clk, reset   : clock, synchronous active-high reset
//   s_tick       : oversampling strobe, OS strobes per bit
//   tx_valid     : word offered on tx_din with par_mode and stop2
//   tx_din       : data word, sent LSB first
//   par_mode     : 00 none, 01 even, 10 odd, 11 none
//   stop2        : 0 -> SB_TICK stop ticks, 1 -> 2*SB_TICK stop ticks
//   tx_ready     : holding register empty
//   tx_busy      : FSM not idle
//   tx_done_tick : one-cycle pulse on the last stop tick
//   tx           : registered serial line, idles high
module uart_tx_cfg
    import uart_tx_cfg_pkg::*;
#(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned OS      = 16,
    parameter int unsigned SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_valid,
    input  logic [DBIT-1:0] tx_din,
    input  logic [1:0]      par_mode,
    input  logic            stop2,
    output logic            tx_ready,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx
);

    localparam int unsigned TMAX = (OS > 2 * SB_TICK) ? OS : 2 * SB_TICK;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int unsigned BW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [TW-1:0] OS_LAST  = TW'(OS - 1);
    localparam logic [TW-1:0] ST1_LAST = TW'(SB_TICK - 1);
    localparam logic [TW-1:0] ST2_LAST = TW'(2 * SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

    tx_state_t       state_reg,   state_next;
    logic [TW-1:0]   tick_reg,    tick_next;
    logic [BW-1:0]   bit_reg,     bit_next;
    logic [DBIT-1:0] shift_reg,   shift_next;
    logic            par_en_reg,  par_en_next;
    logic            par_bit_reg, par_bit_next;
    logic            stop2_reg,   stop2_next;
    logic            tx_reg,      tx_next;

    logic            take;
    logic            hold_full;
    logic            hold_avail;
    logic [DBIT-1:0] hold_data;
    logic [1:0]      hold_par;
    logic            hold_stop2;
    logic [TW-1:0]   tick_last;
    logic            unit_end;

    uart_tx_hold #(
        .DBIT(DBIT)
    ) u_hold (
        .clk       (clk),
        .reset     (reset),
        .load      (tx_valid),
        .load_data (tx_din),
        .load_par  (par_mode),
        .load_stop2(stop2),
        .take      (take),
        .ready     (tx_ready),
        .full      (hold_full),
        .avail     (hold_avail),
        .data      (hold_data),
        .par       (hold_par),
        .stop2     (hold_stop2)
    );

    // Last tick index of the current bit (or of the whole stop period).
    assign tick_last = (state_reg == STOP) ? (stop2_reg ? ST2_LAST : ST1_LAST) : OS_LAST;
    assign unit_end  = s_tick && (tick_reg == tick_last);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            tick_reg    <= '0;
            bit_reg     <= '0;
            shift_reg   <= '0;
            par_en_reg  <= 1'b0;
            par_bit_reg <= 1'b0;
            stop2_reg   <= 1'b0;
            tx_reg      <= 1'b1;
        end else begin
            state_reg   <= state_next;
            tick_reg    <= tick_next;
            bit_reg     <= bit_next;
            shift_reg   <= shift_next;
            par_en_reg  <= par_en_next;
            par_bit_reg <= par_bit_next;
            stop2_reg   <= stop2_next;
            tx_reg      <= tx_next;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        state_next   = state_reg;
        tick_next    = tick_reg;
        bit_next     = bit_reg;
        shift_next   = shift_reg;
        par_en_next  = par_en_reg;
        par_bit_next = par_bit_reg;
        stop2_next   = stop2_reg;
        take         = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (hold_full) begin
                    state_next = START;
                end
            end
            START: begin
                if (unit_end) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (unit_end) begin
                    shift_next = shift_reg >> 1;
                    if (bit_reg == BIT_LAST) begin
                        state_next = par_en_reg ? PARITY : STOP;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (unit_end) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                if (unit_end) begin
                    // hold_avail includes a word accepted this very cycle.
                    state_next = hold_avail ? START : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (state_next != state_reg || (state_reg == DATA && unit_end)) begin
            tick_next = '0;
        end else if (s_tick && state_reg != IDLE) begin
            tick_next = tick_reg + 1'b1;
        end

        if (state_next == START && state_reg != START) begin
            take         = 1'b1;
            bit_next     = '0;
            shift_next   = hold_data;
            par_en_next  = par_enabled(hold_par);
            par_bit_next = (^hold_data) ^ (hold_par == PAR_ODD);
            stop2_next   = hold_stop2;
        end

        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            PARITY:  tx_next = par_bit_next;
            default: tx_next = 1'b1;
        endcase
    end

    // Outputs.
    always_comb begin
        tx_busy      = (state_reg != IDLE);
        tx_done_tick = (state_reg == STOP) && unit_end;
        tx           = tx_reg;
    end

endmodule
